// File: rtl/zbb_pkg.sv
// Shared encodings for the iterative Zbb count sequencer.
// Op codes match the execute-stage decode; state codes are internal to the FSM.
package zbb_pkg;

    localparam logic [1:0] ZBBCNT_CLZ  = 2'd0;
    localparam logic [1:0] ZBBCNT_CTZ  = 2'd1;
    localparam logic [1:0] ZBBCNT_CPOP = 2'd2;

    localparam int DEFAULT_STEP = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/zbb_count_seq_if.sv
// Request/response bundle between the execute stage (master) and the count sequencer (slave).
interface zbb_count_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd;
    logic        busy;

    modport master (
        output req_valid, req_op, req_rs1, kill, resp_ready,
        input  req_ready, resp_valid, resp_rd, busy
    );

    modport slave (
        input  req_valid, req_op, req_rs1, kill, resp_ready,
        output req_ready, resp_valid, resp_rd, busy
    );
endinterface

// File: rtl/zbb_chunk_count.sv
// Counts within one STEP-bit chunk: zeros before the first set bit, population, non-zero flag.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module zbb_chunk_count
    import zbb_pkg::*;
#(
    parameter int STEP = DEFAULT_STEP
) (
    input  logic [STEP-1:0] chunk,
    input  logic [1:0]      op,
    output logic [3:0]      zeroCnt,
    output logic [3:0]      popCnt,
    output logic            nonZero
);

    logic [STEP-1:0] revChunk;
    logic [STEP-1:0] scanVec;
    logic            seen;

    // Leading zeros of the chunk are the trailing zeros of its bit reversal.
    assign revChunk = {<<{chunk}};
    assign scanVec  = (op == ZBBCNT_CLZ) ? revChunk : chunk;
    assign nonZero  = |chunk;

    always_comb begin
        zeroCnt = 4'd0;
        popCnt  = 4'd0;
        seen    = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            popCnt = popCnt + 4'(chunk[i]);
            if (!seen) begin
                if (scanVec[i]) seen = 1'b1;
                else            zeroCnt = zeroCnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/zbb_count_seq.sv
// Iterative clz/ctz/cpop: examines STEP bits of rs1 per cycle, early exit for clz/ctz.
// Latency: 1..32/STEP RUN cycles after accept (cpop always 32/STEP); reserved op 3 answers with 0 directly.
// Backpressure: accepts only in IDLE; result held in DONE until resp_ready; kill aborts silently.
module zbb_count_seq
    import zbb_pkg::*;
#(
    parameter int STEP = DEFAULT_STEP
) (
    input  logic          clk,
    input  logic          rst_n,
    zbb_count_seq_if.slave bus
);

    localparam int NCHUNK = 32 / STEP;
    localparam int IDXW   = $clog2(NCHUNK);

    state_t          state;
    logic [31:0]     shReg;
    logic [5:0]      cntReg;
    logic [IDXW-1:0] idxReg;
    logic [1:0]      opReg;
    logic [5:0]      respRdReg;

    logic [STEP-1:0] chunk;
    logic [3:0]      zeroCnt;
    logic [3:0]      popCnt;
    logic            nonZero;
    logic [5:0]      cntNext;
    logic            runDone;

    // CLZ walks from the MSB end, CTZ and CPOP from the LSB end.
    assign chunk = (opReg == ZBBCNT_CLZ) ? shReg[31 -: STEP] : shReg[STEP-1:0];

    zbb_chunk_count #(.STEP(STEP)) u_chunk (
        .chunk   (chunk),
        .op      (opReg),
        .zeroCnt (zeroCnt),
        .popCnt  (popCnt),
        .nonZero (nonZero)
    );

    always_comb begin
        cntNext = cntReg;
        if (opReg == ZBBCNT_CPOP)  cntNext = cntReg + 6'(popCnt);
        else if (nonZero)          cntNext = cntReg + 6'(zeroCnt);
        else                       cntNext = cntReg + 6'(STEP);
        runDone = (idxReg == IDXW'(NCHUNK - 1)) || ((opReg != ZBBCNT_CPOP) && nonZero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shReg     <= '0;
            cntReg    <= '0;
            idxReg    <= '0;
            opReg     <= ZBBCNT_CLZ;
            respRdReg <= '0;
        end else if (bus.kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        opReg  <= bus.req_op;
                        shReg  <= bus.req_rs1;
                        cntReg <= '0;
                        idxReg <= '0;
                        if (bus.req_op == 2'd3) begin
                            respRdReg <= '0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    shReg  <= (opReg == ZBBCNT_CLZ) ? (shReg << STEP) : (shReg >> STEP);
                    cntReg <= cntNext;
                    idxReg <= idxReg + 1'b1;
                    if (runDone) begin
                        respRdReg <= cntNext;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = (state == S_DONE);
    assign bus.resp_rd    = {26'd0, respRdReg};

endmodule
